// File: rtl/ext_apb_mst_bridge_if.sv
// Bundle of the upstream ext_* request/ack signals and the downstream APB3
// master signals carried by ext_apb_mst_bridge.
//
// Handshake: ext_req_vld is a one-cycle pulse that qualifies ext_wr_en,
// ext_rd_en, ext_addr and ext_wr_data in that same cycle. The request is
// accepted only in IDLE or RESP. Every accepted request, and no other, is
// answered by exactly one ext_ack_vld pulse. ext_rd_data and ext_err are
// meaningful only while ext_ack_vld is 1, and are 0 at all other times.
// The APB side follows APB3: PSEL for a one-cycle setup phase, then
// PSEL+PENABLE until PREADY completes the access.
//
// The 'master' modport is the bridge. It serves requests and is the APB
// master. The 'slave' modport is its environment: the requester plus the
// downstream APB slave.
interface ext_apb_mst_bridge_if #(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 32
);
  logic                  ext_req_vld;
  logic                  ext_wr_en;
  logic                  ext_rd_en;
  logic [ADDR_WIDTH-1:0] ext_addr;
  logic [DATA_WIDTH-1:0] ext_wr_data;
  logic                  ext_ack_vld;
  logic [DATA_WIDTH-1:0] ext_rd_data;
  logic                  ext_err;
  logic                  busy_drop;
  logic                  m_PSEL;
  logic                  m_PENABLE;
  logic                  m_PWRITE;
  logic [ADDR_WIDTH-1:0] m_PADDR;
  logic [DATA_WIDTH-1:0] m_PWDATA;
  logic                  m_PREADY;
  logic                  m_PSLVERR;
  logic [DATA_WIDTH-1:0] m_PRDATA;

  modport master (
    input  ext_req_vld, ext_wr_en, ext_rd_en, ext_addr, ext_wr_data,
    input  m_PREADY, m_PSLVERR, m_PRDATA,
    output ext_ack_vld, ext_rd_data, ext_err, busy_drop,
    output m_PSEL, m_PENABLE, m_PWRITE, m_PADDR, m_PWDATA
  );

  modport slave (
    output ext_req_vld, ext_wr_en, ext_rd_en, ext_addr, ext_wr_data,
    output m_PREADY, m_PSLVERR, m_PRDATA,
    input  ext_ack_vld, ext_rd_data, ext_err, busy_drop,
    input  m_PSEL, m_PENABLE, m_PWRITE, m_PADDR, m_PWDATA
  );
endinterface

// File: rtl/ext_apb_mst_bridge.sv
// ext_apb_mst_bridge: turns single-beat ext_* register requests into one
// APB3 master transfer each. It returns the read data and an error flag on a
// one-cycle ack. A downstream timeout keeps a hung slave from stalling the
// requester. All outputs are registered.
module ext_apb_mst_bridge #(
  parameter int                    ADDR_WIDTH   = 64,
  parameter int                    DATA_WIDTH   = 32,
  parameter int                    TIMEOUT_CYC  = 255,
  parameter logic [DATA_WIDTH-1:0] TIMEOUT_DATA = DATA_WIDTH'(32'hDEAD_BEEF)
) (
  input  logic                     PCLK,
  input  logic                     PRESET,
  input  logic                     sync_reset,
  ext_apb_mst_bridge_if.master     bus,
  output logic [1:0]               o_dbg_state
);

  // Wide enough to hold TIMEOUT_CYC. When the timeout is disabled the
  // counter still runs, but it is never compared.
  localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

  state_t                r_state;
  logic                  r_ack;
  logic                  r_err;
  logic [DATA_WIDTH-1:0] r_rd_data;
  logic                  r_busy_drop;
  logic                  r_psel;
  logic                  r_penable;
  logic                  r_pwrite;
  logic [ADDR_WIDTH-1:0] r_paddr;
  logic [DATA_WIDTH-1:0] r_pwdata;
  logic [CNT_W-1:0]      r_cnt;

  logic [CNT_W-1:0]      w_cnt_inc;
  logic                  w_timeout;
  logic                  w_cmd_ok;

  // w_cnt_inc counts the current ACCESS cycle as well. The timeout fires at
  // the end of ACCESS cycle number TIMEOUT_CYC.
  assign w_cnt_inc = r_cnt + 1'b1;
  assign w_timeout = (TIMEOUT_CYC != 0) && (w_cnt_inc == CNT_W'(TIMEOUT_CYC));
  // A legal command asks for exactly one direction.
  assign w_cmd_ok  = bus.ext_wr_en ^ bus.ext_rd_en;

  assign bus.ext_ack_vld = r_ack;
  assign bus.ext_rd_data = r_rd_data;
  assign bus.ext_err     = r_err;
  assign bus.busy_drop   = r_busy_drop;
  assign bus.m_PSEL      = r_psel;
  assign bus.m_PENABLE   = r_penable;
  assign bus.m_PWRITE    = r_pwrite;
  assign bus.m_PADDR     = r_paddr;
  assign bus.m_PWDATA    = r_pwdata;
  assign o_dbg_state     = r_state;

  // Bridge FSM: sequences the APB phases and registers every output.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      r_state     <= ST_IDLE;
      r_ack       <= 1'b0;
      r_err       <= 1'b0;
      r_rd_data   <= '0;
      r_busy_drop <= 1'b0;
      r_psel      <= 1'b0;
      r_penable   <= 1'b0;
      r_pwrite    <= 1'b0;
      r_paddr     <= '0;
      r_pwdata    <= '0;
      r_cnt       <= '0;
    end else if (sync_reset) begin
      // Abort with no ack. The APB address, data and direction keep their
      // last values, as they do after a normal transfer.
      r_state     <= ST_IDLE;
      r_ack       <= 1'b0;
      r_err       <= 1'b0;
      r_rd_data   <= '0;
      r_busy_drop <= 1'b0;
      r_psel      <= 1'b0;
      r_penable   <= 1'b0;
      r_cnt       <= '0;
    end else begin
      // The ack fields are one-cycle pulses unless a branch below sets them.
      r_ack     <= 1'b0;
      r_err     <= 1'b0;
      r_rd_data <= '0;
      case (r_state)
        ST_IDLE, ST_RESP: begin
          r_psel    <= 1'b0;
          r_penable <= 1'b0;
          r_cnt     <= '0;
          if (bus.ext_req_vld) begin
            r_pwrite <= bus.ext_wr_en;
            r_paddr  <= bus.ext_addr;
            r_pwdata <= bus.ext_wr_data;
            if (w_cmd_ok) begin
              r_state <= ST_SETUP;
              r_psel  <= 1'b1;
            end else begin
              // Malformed command: answer at once with an error and do no
              // APB access.
              r_state <= ST_RESP;
              r_ack   <= 1'b1;
              r_err   <= 1'b1;
            end
          end else begin
            r_state <= ST_IDLE;
          end
        end

        ST_SETUP: begin
          if (bus.ext_req_vld) r_busy_drop <= 1'b1;
          r_state   <= ST_ACCESS;
          r_penable <= 1'b1;
          r_cnt     <= '0;
        end

        ST_ACCESS: begin
          if (bus.ext_req_vld) r_busy_drop <= 1'b1;
          r_cnt <= w_cnt_inc;
          if (bus.m_PREADY) begin
            // PREADY is checked first, so it takes priority over a timeout
            // that expires in the same cycle.
            r_state   <= ST_RESP;
            r_psel    <= 1'b0;
            r_penable <= 1'b0;
            r_cnt     <= '0;
            r_ack     <= 1'b1;
            r_err     <= bus.m_PSLVERR;
            r_rd_data <= r_pwrite ? '0 : bus.m_PRDATA;
          end else if (w_timeout) begin
            r_state   <= ST_RESP;
            r_psel    <= 1'b0;
            r_penable <= 1'b0;
            r_cnt     <= '0;
            r_ack     <= 1'b1;
            r_err     <= 1'b1;
            r_rd_data <= TIMEOUT_DATA;
          end
        end

        default: begin
          r_state   <= ST_IDLE;
          r_psel    <= 1'b0;
          r_penable <= 1'b0;
          r_cnt     <= '0;
        end
      endcase
    end
  end

endmodule
